// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared types, reset values and load validation for the alarm clock core.
package alarm_clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
        logic pm;
    } hms_t;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

    localparam hms_t HMS_RST_24 = '{h1: 4'd0, h0: 4'd0, m1: 4'd0, m0: 4'd0, s1: 4'd0, s0: 4'd0, pm: 1'b0};
    localparam hms_t HMS_RST_12 = '{h1: 4'd1, h0: 4'd2, m1: 4'd0, m0: 4'd0, s1: 4'd0, s0: 4'd0, pm: 1'b0};

    function automatic logic bcd_hms_valid(input hms_t t, input logic mode12);
        logic [6:0] hrs;
        hrs = 7'(t.h1) * 7'd10 + 7'(t.h0);
        return t.h1 <= 4'd9 && t.h0 <= 4'd9 && t.m1 <= 4'd5 && t.m0 <= 4'd9 &&
               t.s1 <= 4'd5 && t.s0 <= 4'd9 &&
               (mode12 ? (hrs >= 7'd1 && hrs <= 7'd12) : hrs <= 7'd23);
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: seconds prescaler and BCD HH:MM:SS register with load and 12h/24h rollover.
module bcd_time_counter
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter bit MODE_12H = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  hms_t load_val,
    output hms_t time_q,
    output hms_t time_nxt,
    output logic tick,
    output logic min_roll
);
    localparam int PW = $clog2(CLK_HZ);

    logic [PW-1:0] presc;
    logic tick_raw, c_s0, c_s1, c_m0, c_m1;

    assign tick_raw = presc == PW'(CLK_HZ - 1);
    // a load in the tick cycle swallows that tick, so downstream never sees it
    assign tick     = tick_raw && !load;
    assign min_roll = tick && c_s1;

    always_comb begin
        c_s0 = time_q.s0 == 4'd9;
        c_s1 = c_s0 && time_q.s1 == 4'd5;
        c_m0 = c_s1 && time_q.m0 == 4'd9;
        c_m1 = c_m0 && time_q.m1 == 4'd5;
        time_nxt = time_q;
        time_nxt.s0 = c_s0 ? 4'd0 : time_q.s0 + 4'd1;
        if (c_s0) time_nxt.s1 = c_s1 ? 4'd0 : time_q.s1 + 4'd1;
        if (c_s1) time_nxt.m0 = c_m0 ? 4'd0 : time_q.m0 + 4'd1;
        if (c_m0) time_nxt.m1 = c_m1 ? 4'd0 : time_q.m1 + 4'd1;
        if (c_m1) begin
            if (MODE_12H && time_q.h1 == 4'd1 && time_q.h0 == 4'd1) begin
                time_nxt.h0 = 4'd2;
                time_nxt.pm = ~time_q.pm;
            end else if (MODE_12H && time_q.h1 == 4'd1 && time_q.h0 == 4'd2) begin
                time_nxt.h1 = 4'd0;
                time_nxt.h0 = 4'd1;
            end else if (!MODE_12H && time_q.h1 == 4'd2 && time_q.h0 == 4'd3) begin
                time_nxt.h1 = 4'd0;
                time_nxt.h0 = 4'd0;
            end else if (time_q.h0 == 4'd9) begin
                time_nxt.h1 = time_q.h1 + 4'd1;
                time_nxt.h0 = 4'd0;
            end else begin
                time_nxt.h0 = time_q.h0 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            time_q <= MODE_12H ? HMS_RST_12 : HMS_RST_24;
        end else if (load) begin
            presc  <= '0;
            time_q <= load_val;
        end else begin
            presc <= tick_raw ? '0 : presc + 1'b1;
            if (tick_raw) time_q <= time_nxt;
        end
    end

endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: timekeeping, alarm register, alarm/snooze FSM and BCD display mux.
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter bit MODE_12H   = 1'b0,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MAX_S = 60
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       set_valid,
    input  logic       set_target,
    input  logic [3:0] set_h1,
    input  logic [3:0] set_h0,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    input  logic [3:0] set_s1,
    input  logic [3:0] set_s0,
    input  logic       set_pm,
    output logic       set_err,
    input  logic       alarm_enable,
    input  logic       snooze,
    input  logic       stop,
    input  logic       display_sel,
    output logic [3:0] display_h1_export,
    output logic [3:0] display_h0_export,
    output logic [3:0] display_m1_export,
    output logic [3:0] display_m0_export,
    output logic [3:0] display_s1_export,
    output logic [3:0] display_s0_export,
    output logic       pm,
    output logic       alarm_active
);
    hms_t ld, time_q, time_nxt, alarm_q, shown;
    logic ok, time_load, alarm_load, tick, min_roll;
    alarm_state_t state, state_nxt;
    logic [7:0] ring_cnt, ring_nxt;
    logic [3:0] snz_cnt, snz_nxt;

    // alarm loads carry zero seconds so the match is a plain struct compare
    assign ld = '{h1: set_h1, h0: set_h0, m1: set_m1, m0: set_m0,
                  s1: set_target ? 4'd0 : set_s1, s0: set_target ? 4'd0 : set_s0,
                  pm: MODE_12H && set_pm};
    assign ok         = bcd_hms_valid(ld, MODE_12H);
    assign time_load  = set_valid && !set_target && ok;
    assign alarm_load = set_valid && set_target && ok;

    bcd_time_counter #(.CLK_HZ(CLK_HZ), .MODE_12H(MODE_12H)) u_counter (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .load     (time_load),
        .load_val (ld),
        .time_q   (time_q),
        .time_nxt (time_nxt),
        .tick     (tick),
        .min_roll (min_roll)
    );

    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_cnt;
        snz_nxt   = snz_cnt;
        if (!alarm_enable || alarm_load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (tick && time_nxt == alarm_q) begin
                    state_nxt = RINGING;
                    ring_nxt  = '0;
                end
                RINGING: if (stop) begin
                    state_nxt = IDLE;
                end else if (snooze) begin
                    state_nxt = SNOOZED;
                    snz_nxt   = 4'(SNOOZE_MIN);
                    ring_nxt  = '0;
                end else if (tick) begin
                    state_nxt = ring_cnt == 8'(RING_MAX_S - 1) ? IDLE : RINGING;
                    ring_nxt  = ring_cnt + 8'd1;
                end
                SNOOZED: if (stop) begin
                    state_nxt = IDLE;
                end else if (min_roll) begin
                    state_nxt = snz_cnt == 4'd1 ? RINGING : SNOOZED;
                    snz_nxt   = snz_cnt - 4'd1;
                    ring_nxt  = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            set_err  <= 1'b0;
            alarm_q  <= MODE_12H ? HMS_RST_12 : HMS_RST_24;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_nxt;
            snz_cnt  <= snz_nxt;
            set_err  <= set_valid && !ok;
            if (alarm_load) alarm_q <= ld;
        end
    end

    assign alarm_active      = state == RINGING;
    assign shown             = display_sel ? alarm_q : time_q;
    assign display_h1_export = shown.h1;
    assign display_h0_export = shown.h0;
    assign display_m1_export = shown.m1;
    assign display_m0_export = shown.m0;
    assign display_s1_export = shown.s1;
    assign display_s0_export = shown.s0;
    assign pm                = shown.pm;

endmodule
